instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch initiator for the combinational big-endian instruction ROM. Owns the PC, drives the ROM enable and address, and captures each returned word into a small prefetch FIFO.
- Presents instructions to decode through a valid/ready handshake.
- Handles branch/jump redirects from later stages by flushing the buffered instructions and restarting the fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
- DEPTH, 2, prefetch FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rom_en  out  1  ROM enable; a fetch happens this cycle
- rom_addr  out  32  ROM byte address; always word-aligned (bits [1:0] = 0)
- rom_instr  in  32  ROM read data; valid in the same cycle (combinational ROM)
- redirect  in  1  branch/jump taken; flush and restart
- redirect_pc  in  32  redirect target; bits [1:0] ignored
- out_valid  out  1  head instruction available to decode
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  32  head instruction word
- out_pc  out  32  byte address of the head instruction

Behaviour:
- Reset (async assert, sync release): pc = RESET_PC, FIFO count = 0, started = 0.
  - Outputs during reset: rom_en = 0, out_valid = 0, out_instr = 0, out_pc = 0.
- started: set on the first clk edge after rst_n deasserts. rom_en stays 0 until started = 1, so the first fetch is one cycle after release.
- rom_addr = {pc[31:2], 2'b00}, driven combinationally, at all times.
- Fetch condition: rom_en = started & ~redirect & (count < DEPTH).
  - A pop in the same cycle does not make room; the full-FIFO condition uses the registered count only.
- On a fetch: push {rom_instr, rom_addr} into the FIFO, then pc <= pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- No fetch, no redirect: pc holds.
- Pop: out_valid & out_ready removes the head at the clock edge.
  - Push and pop in the same cycle: count unchanged.
- out_valid = (count != 0).
- out_instr / out_pc are the head entry. They must stay stable while out_valid = 1 and out_ready = 0.
- When count = 0: out_instr = 0 (NOP), out_pc = 0.
- Redirect (priority over everything):
  - Same cycle: rom_en = 0; any pop or push is ignored.
  - Next edge: count <= 0, pc <= {redirect_pc[31:2], 2'b00}.
  - The next fetch happens the cycle after the redirect, at the target.
- Redirect with out_valid & out_ready in the same cycle: the accepted head is discarded. Decode must treat that cycle's instruction as killed; this is the documented contract.
- Back-to-back redirects: the last one wins; no fetch occurs until redirect drops.
- Latency: instruction at address A is on out_* in the cycle after A is fetched (1 cycle). Sustained throughput is 1 instr/cycle while out_ready = 1.
- Full FIFO: fetch pauses and pc holds, so no instruction is lost or duplicated.
- Reset mid-operation: all state clears immediately; rom_en drops asynchronously.

Decomposition:
- Shared package cpu_defs_pkg:
  - INSTR_W = 32, ADDR_W = 32
  - NOP_INSTR = 32'h0
  - PC_STEP = 4
  - RESET_PC default
- One sub-module: fetch_fifo.
  - Synchronous FIFO with DEPTH entries of {instr, pc} (64 bits).
  - push / pop / clear (clear has priority), count, head outputs, async active-low reset.
- instr_fetch holds the PC, the started flag and the control logic, and instantiates fetch_fifo.

Test Plan:
- ROM model preloaded bytes 00..0F = 11 22 33 44 55 66 77 88 99 AA BB CC DD EE FF 00; RESET_PC = 0; out_ready = 1.
  - After release: rom_en rises 1 cycle later; rom_addr = 0,4,8,C in successive cycles.
  - out_instr = 32'h11223344, 32'h55667788, ... each with the matching out_pc, one per cycle.
- Backpressure: hold out_ready = 0 from cycle 2.
  - Two entries fill, then rom_en = 0 and pc holds at 8.
  - out_instr stays 32'h11223344.
  - After release of out_ready, the stream continues 55667788, 99AABBCC with no gap or duplicate.
- Redirect: pulse redirect with redirect_pc = 32'h0000_000E while the FIFO holds 2 entries.
  - That cycle: rom_en = 0.
  - Next cycle: out_valid = 0 and rom_addr = 32'h0000_000C.
  - Following cycle: out_instr = 32'hDDEEFF00, out_pc = 32'hC.
- Redirect coincident with out_valid & out_ready: FIFO empty the next cycle; no entry from the old path ever appears on out_*.
- Wrap-around: RESET_PC = 32'hFFFF_FFFC. Fetched addresses are FFFF_FFFC then 0000_0000; out_pc sequence matches.
- Async reset asserted mid-stream (between edges): rom_en and out_valid go to 0 immediately. After release, fetching resumes at RESET_PC.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU-wide widths, constants and the fetch FIFO entry layout.
package cpu_defs_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  PC_STEP          = 32'd4;
  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {instr, pc} entries with a combinational head view.
module fetch_fifo
  import cpu_defs_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic             push_ok, pop_ok;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok = push & ~clear & (count_reg != DEPTH_C);
  assign pop_ok  = pop  & ~clear & (count_reg != '0);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign count = count_reg;
  assign head  = mem_reg[rd_ptr_reg];
endmodule

// File: rtl/instr_fetch.sv
// Fetch initiator: owns the PC, drives the combinational ROM and buffers
// fetched words for decode, flushing on redirects.
module instr_fetch
  import cpu_defs_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_instr,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              started_reg;
  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_data;
  logic              fifo_pop;

  assign rom_addr = word_align(pc_reg);

  // Fullness uses the registered count only; a same-cycle pop does not make room.
  assign rom_en    = started_reg & ~redirect & (fifo_count != DEPTH_C);
  assign out_valid = (fifo_count != '0);
  assign fifo_pop  = out_valid & out_ready & ~redirect;

  assign push_data.instr = rom_instr;
  assign push_data.pc    = rom_addr;

  always_comb begin
    pc_next = pc_reg;
    if (redirect)    pc_next = word_align(redirect_pc);
    else if (rom_en) pc_next = rom_addr + PC_STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= RESET_PC;
      started_reg <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      started_reg <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect),
    .push      (rom_en),
    .push_data (push_data),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Empty FIFO presents a NOP so decode never sees stale storage.
  assign out_instr = out_valid ? fifo_head.instr : NOP_INSTR;
  assign out_pc    = out_valid ? fifo_head.pc    : '0;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirects,
// PC wrap-around and asynchronous reset.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic        rom_en, out_valid;
  logic [31:0] rom_addr, rom_instr, out_instr, out_pc;

  logic        w_rom_en, w_out_valid;
  logic [31:0] w_rom_addr, w_rom_instr, w_out_instr, w_out_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Big-endian ROM image 11 22 .. FF 00; addresses beyond it read a tagged pattern.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h1122_3344;
      32'h4:   return 32'h5566_7788;
      32'h8:   return 32'h99AA_BBCC;
      32'hC:   return 32'hDDEE_FF00;
      default: return {16'hBAD0, a[15:0]};
    endcase
  endfunction

  assign rom_instr   = rom_word(rom_addr);
  assign w_rom_instr = rom_word(w_rom_addr);

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_instr(rom_instr), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .rom_en(w_rom_en), .rom_addr(w_rom_addr),
    .rom_instr(w_rom_instr), .redirect(1'b0), .redirect_pc(32'h0),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_instr(w_out_instr),
    .out_pc(w_out_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  initial begin
    logic [31:0] words [4];
    words[0] = 32'h1122_3344; words[1] = 32'h5566_7788;
    words[2] = 32'h99AA_BBCC; words[3] = 32'hDDEE_FF00;

    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rom_en",    {31'b0, rom_en},    32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_instr", out_instr,          32'h0);
    check("rst_out_pc",    out_pc,             32'h0);

    rst_n = 1'b1;
    #1 check("pre_start_rom_en", {31'b0, rom_en}, 32'h0);
    @(negedge clk);
    check("start_rom_en",   {31'b0, rom_en}, 32'h1);
    check("start_rom_addr", rom_addr,        32'h0);
    check("start_valid",    {31'b0, out_valid}, 32'h0);
    check("wrap_addr0",     w_rom_addr,      32'hFFFF_FFFC);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("stream_addr%0d", i), rom_addr, 32'(4 * (i + 1)));
      check($sformatf("stream_instr%0d", i), out_instr, words[i]);
      check($sformatf("stream_pc%0d", i), out_pc, 32'(4 * i));
      if (i == 0) begin
        check("wrap_out_pc0", w_out_pc,   32'hFFFF_FFFC);
        check("wrap_instr0",  w_out_instr, 32'hBAD0_FFFC);
        check("wrap_addr1",   w_rom_addr, 32'h0);
      end
      if (i == 1) begin
        check("wrap_out_pc1", w_out_pc,    32'h0);
        check("wrap_instr1",  w_out_instr, 32'h1122_3344);
      end
    end

    // Redirect to 0 while decode accepts the head: accepted head is killed.
    redirect = 1'b1; redirect_pc = 32'h0;
    #1 check("rdr0_rom_en", {31'b0, rom_en}, 32'h0);
    @(negedge clk);
    redirect = 1'b0; out_ready = 1'b0;
    #1;
    check("rdr0_valid",    {31'b0, out_valid}, 32'h0);
    check("rdr0_rom_addr", rom_addr,           32'h0);
    check("rdr0_rom_en2",  {31'b0, rom_en},    32'h1);

    // Backpressure: two entries fill, then fetch stalls with pc held at 8.
    @(negedge clk);
    check("bp_instr_a", out_instr, 32'h1122_3344);
    check("bp_addr_a",  rom_addr,  32'h4);
    @(negedge clk);
    check("bp_full_en",   {31'b0, rom_en}, 32'h0);
    check("bp_full_addr", rom_addr,        32'h8);
    check("bp_full_instr", out_instr,      32'h1122_3344);
    @(negedge clk);
    check("bp_hold_en",    {31'b0, rom_en}, 32'h0);
    check("bp_hold_addr",  rom_addr,        32'h8);
    check("bp_hold_instr", out_instr,       32'h1122_3344);
    check("bp_hold_pc",    out_pc,          32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_instr", out_instr, 32'h5566_7788);
    check("bp_rel_pc",    out_pc,    32'h4);
    check("bp_rel_en",    {31'b0, rom_en}, 32'h1);
    @(negedge clk);
    check("bp_rel_instr2", out_instr, 32'h99AA_BBCC);
    check("bp_rel_pc2",    out_pc,    32'h8);
    out_ready = 1'b0;
    @(negedge clk);
    check("full2_en", {31'b0, rom_en}, 32'h0);

    // Redirect to 0xE with two entries buffered.
    redirect = 1'b1; redirect_pc = 32'h0000_000E;
    #1 check("rdrE_rom_en", {31'b0, rom_en}, 32'h0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("rdrE_valid",    {31'b0, out_valid}, 32'h0);
    check("rdrE_instr",    out_instr,          32'h0);
    check("rdrE_rom_addr", rom_addr,           32'hC);
    @(negedge clk);
    check("rdrE_out_instr", out_instr, 32'hDDEE_FF00);
    check("rdrE_out_pc",    out_pc,    32'hC);

    // Back-to-back redirects: last target wins, no fetch while asserted.
    redirect = 1'b1; redirect_pc = 32'h4;
    #1 check("b2b_en0", {31'b0, rom_en}, 32'h0);
    @(negedge clk);
    redirect_pc = 32'h8;
    #1 check("b2b_en1", {31'b0, rom_en}, 32'h0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("b2b_addr",  rom_addr,           32'h8);
    check("b2b_valid", {31'b0, out_valid}, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b_out_pc",    out_pc,    32'h8);
    check("b2b_out_instr", out_instr, 32'h99AA_BBCC);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check("arst_rom_en", {31'b0, rom_en},    32'h0);
    check("arst_valid",  {31'b0, out_valid}, 32'h0);
    check("arst_addr",   rom_addr,           32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_rel_en",   {31'b0, rom_en}, 32'h1);
    check("arst_rel_addr", rom_addr,        32'h0);
    @(negedge clk);
    check("arst_rel_instr", out_instr, 32'h1122_3344);
    check("arst_rel_pc",    out_pc,    32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
